// File: rtl/edge_bbox_stat_if.sv
// Binary edge video stream: frame/line valid, pixel qualifier and edge bit.
interface edge_bbox_stat_if;
    logic vsync;
    logic href;
    logic clken;
    logic data;

    modport master (output vsync, output href, output clken, output data);
    modport slave  (input  vsync, input  href, input  clken, input  data);
endinterface

// File: rtl/edge_bbox_stat.sv
// Edge pixel count and bounding box per frame, with 1-clk stream pass-through.
// Optional outline overlay of the last reported box: define EDGE_BBOX_OVERLAY_EN.
module edge_bbox_stat #(
    parameter logic [11:0] IMG_HDISP = 12'd640,
    parameter logic [11:0] IMG_VDISP = 12'd480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    edge_bbox_stat_if.slave      per_img,
    edge_bbox_stat_if.master     post_img,
    output logic                 bbox_valid,
    output logic                 bbox_empty,
    output logic [11:0]          bbox_xmin,
    output logic [11:0]          bbox_xmax,
    output logic [11:0]          bbox_ymin,
    output logic [11:0]          bbox_ymax,
    output logic [23:0]          edge_cnt
);

    localparam int unsigned CW   = 12;
    localparam int unsigned CNTW = 24;

    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

    state_t          state, state_nxt;
    logic            acc_init_c, load_c;
    logic            vsync_d, href_d, clken_d, bit_d, post_vsync;
    logic [CW-1:0]   x_cnt, y_cnt;
    logic [CW-1:0]   acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [CNTW-1:0] acc_cnt;
    logic            acc_any;
    logic            valid_c, rise_c, fall_c, href_fall_c, in_range_c, edge_pix_c;
    logic            ovl_hit_c;

    assign valid_c     = per_img.href & per_img.clken;
    assign rise_c      = per_img.vsync & ~vsync_d;
    assign fall_c      = ~per_img.vsync & vsync_d;
    assign href_fall_c = ~per_img.href & href_d;
    assign in_range_c  = (x_cnt < IMG_HDISP) && (y_cnt < IMG_VDISP);
    // Pixel sampled while vsync is low (the fall cycle) never counts.
    assign edge_pix_c  = valid_c & per_img.data & per_img.vsync & in_range_c;

    // vsync_d resets high so a frame already in progress at reset release is not seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b1;
            post_vsync <= 1'b0;
            href_d     <= 1'b0;
            clken_d    <= 1'b0;
            bit_d      <= 1'b0;
        end else begin
            vsync_d    <= per_img.vsync;
            post_vsync <= per_img.vsync;
            href_d     <= per_img.href;
            clken_d    <= per_img.clken;
            bit_d      <= per_img.data | ovl_hit_c;
        end
    end

    assign post_img.vsync = post_vsync;
    assign post_img.href  = href_d;
    assign post_img.clken = clken_d;
    assign post_img.data  = bit_d;

    // Pixel coordinates; x saturates at IMG_HDISP, y at IMG_VDISP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (!per_img.href)
                x_cnt <= '0;
            else if (valid_c && (x_cnt != IMG_HDISP))
                x_cnt <= x_cnt + CW'(1);

            if (rise_c)
                y_cnt <= '0;
            else if (href_fall_c && (y_cnt != IMG_VDISP))
                y_cnt <= y_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        acc_init_c = 1'b0;
        load_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise_c) begin
                    state_nxt  = ACTIVE;
                    acc_init_c = 1'b1;
                end
            end
            ACTIVE: begin
                if (fall_c) begin
                    state_nxt = REPORT;
                    load_c    = 1'b1;
                end
            end
            REPORT: begin
                if (rise_c) begin
                    state_nxt  = ACTIVE;
                    acc_init_c = 1'b1;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_xmin <= '0;
            acc_xmax <= '0;
            acc_ymin <= '0;
            acc_ymax <= '0;
            acc_cnt  <= '0;
            acc_any  <= 1'b0;
        end else if (acc_init_c) begin
            acc_xmin <= IMG_HDISP - CW'(1);
            acc_xmax <= '0;
            acc_ymin <= IMG_VDISP - CW'(1);
            acc_ymax <= '0;
            acc_cnt  <= '0;
            acc_any  <= 1'b0;
        end else if ((state == ACTIVE) && edge_pix_c) begin
            if (x_cnt < acc_xmin) acc_xmin <= x_cnt;
            if (x_cnt > acc_xmax) acc_xmax <= x_cnt;
            if (y_cnt < acc_ymin) acc_ymin <= y_cnt;
            if (y_cnt > acc_ymax) acc_ymax <= y_cnt;
            if (acc_cnt != {CNTW{1'b1}}) acc_cnt <= acc_cnt + CNTW'(1);
            acc_any <= 1'b1;
        end
    end

    // Results load on the fall edge so bbox_valid coincides with the REPORT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bbox_valid <= 1'b0;
            bbox_empty <= 1'b0;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            edge_cnt   <= '0;
        end else begin
            bbox_valid <= load_c;
            if (load_c) begin
                bbox_empty <= ~acc_any;
                bbox_xmin  <= acc_any ? acc_xmin : '0;
                bbox_xmax  <= acc_any ? acc_xmax : '0;
                bbox_ymin  <= acc_any ? acc_ymin : '0;
                bbox_ymax  <= acc_any ? acc_ymax : '0;
                edge_cnt   <= acc_any ? acc_cnt  : '0;
            end
        end
    end

`ifdef EDGE_BBOX_OVERLAY_EN
    logic ovl_on;
    logic on_vert_c, on_horz_c;

    // Overlay enabled only once a non-empty box has been reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ovl_on <= 1'b0;
        else if (load_c) ovl_on <= acc_any;
    end

    assign on_vert_c = ((x_cnt == bbox_xmin) || (x_cnt == bbox_xmax)) &&
                       (y_cnt >= bbox_ymin) && (y_cnt <= bbox_ymax);
    assign on_horz_c = ((y_cnt == bbox_ymin) || (y_cnt == bbox_ymax)) &&
                       (x_cnt >= bbox_xmin) && (x_cnt <= bbox_xmax);
    assign ovl_hit_c = ovl_on & valid_c & (on_vert_c | on_horz_c);
`else
    assign ovl_hit_c = 1'b0;
`endif

endmodule

// File: tb/tb_edge_bbox_stat.sv
// Scoreboard bench for edge_bbox_stat on an 8x6 image; build with EDGE_BBOX_OVERLAY_EN for overlay checks.
module tb_edge_bbox_stat;

    localparam int HD   = 8;
    localparam int VD   = 6;
    localparam int MAXW = 10;

    typedef struct packed {
        logic        empty;
        logic [11:0] xmin;
        logic [11:0] xmax;
        logic [11:0] ymin;
        logic [11:0] ymax;
        logic [23:0] cnt;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_bbox_stat_if per_if ();
    edge_bbox_stat_if post_if ();

    logic        bbox_valid, bbox_empty;
    logic [11:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic [23:0] edge_cnt;

    edge_bbox_stat #(.IMG_HDISP(12'd8), .IMG_VDISP(12'd6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .per_img    (per_if),
        .post_img   (post_if),
        .bbox_valid (bbox_valid),
        .bbox_empty (bbox_empty),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .edge_cnt   (edge_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t last_res  = '0;
    logic ovl_on_m  = 1'b0;
    logic pix_map [0:VD-1][0:MAXW-1];
    int   cur_x = -1, cur_y = -1;
    logic s_ok = 1'b0, s_vs = 1'b0, s_hr = 1'b0, s_ck = 1'b0, s_bt = 1'b0;
    int   s_x = -1, s_y = -1;
    logic count_ovl = 1'b0;
    int   ovl_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model_frame(input int line_len);
        res_t r;
        int   n = 0;
        int   xmn = HD, xmx = -1, ymn = VD, ymx = -1;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < line_len && x < HD; x++)
                if (pix_map[y][x]) begin
                    n++;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
        r = '0;
        if (n == 0) r.empty = 1'b1;
        else begin
            r.xmin = 12'(xmn); r.xmax = 12'(xmx);
            r.ymin = 12'(ymn); r.ymax = 12'(ymx);
            r.cnt  = 24'(n);
        end
        return r;
    endfunction

    function automatic logic on_box(input int x, input int y);
        int xa = int'(last_res.xmin), xb = int'(last_res.xmax);
        int ya = int'(last_res.ymin), yb = int'(last_res.ymax);
        return (((x == xa) || (x == xb)) && (y >= ya) && (y <= yb)) ||
               (((y == ya) || (y == yb)) && (x >= xa) && (x <= xb));
    endfunction

    task automatic clear_map();
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < MAXW; x++)
                pix_map[y][x] = 1'b0;
    endtask

    task automatic tick(input logic vs, input logic hr, input logic ck, input logic bt,
                        input int x, input int y);
        @(posedge clk);
        #1;
        per_if.vsync = vs; per_if.href = hr; per_if.clken = ck; per_if.data = bt;
        cur_x = x; cur_y = y;
    endtask

    // One line: noise cycle (clken=0, bit=1) before every pixel, then an href gap with bit=1.
    task automatic drive_line(input int y, input int line_len);
        for (int x = 0; x < line_len; x++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
            tick(1'b1, 1'b1, 1'b1, pix_map[y][x], x, y);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        tick(1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_empty"}, 32'(bbox_empty), 32'(last_res.empty));
        chk({tag, "_xmin"},  32'(bbox_xmin),  32'(last_res.xmin));
        chk({tag, "_xmax"},  32'(bbox_xmax),  32'(last_res.xmax));
        chk({tag, "_ymin"},  32'(bbox_ymin),  32'(last_res.ymin));
        chk({tag, "_ymax"},  32'(bbox_ymax),  32'(last_res.ymax));
        chk({tag, "_cnt"},   32'(edge_cnt),   32'(last_res.cnt));
    endtask

    task automatic run_frame(input string tag, input int line_len);
        exp_q.push_back(model_frame(line_len));
        tick(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        for (int y = 0; y < VD; y++) drive_line(y, line_len);
        tick(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_on"}, 32'(bbox_valid), 32'd1);
        @(negedge clk);
        chk({tag, "_valid_off"}, 32'(bbox_valid), 32'd0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        check_hold({tag, "_hold"});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_ok <= 1'b0;
        else begin
            s_ok <= 1'b1;
            s_vs <= per_if.vsync; s_hr <= per_if.href;
            s_ck <= per_if.clken; s_bt <= per_if.data;
            s_x  <= cur_x;        s_y  <= cur_y;
        end
    end

    // Pass-through, overlay and result scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_ok) begin
                logic exp_bit;
                exp_bit = s_bt;
`ifdef EDGE_BBOX_OVERLAY_EN
                if (ovl_on_m && s_hr && s_ck && on_box(s_x, s_y)) exp_bit = 1'b1;
`endif
                chk("pt_vsync", 32'(post_if.vsync), 32'(s_vs));
                chk("pt_href",  32'(post_if.href),  32'(s_hr));
                chk("pt_clken", 32'(post_if.clken), 32'(s_ck));
                chk("pt_bit",   32'(post_if.data),  32'(exp_bit));
                if (count_ovl && s_hr && s_ck && post_if.data) ovl_cnt++;
            end
            if (bbox_valid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("res_empty", 32'(bbox_empty), 32'(e.empty));
                    chk("res_xmin",  32'(bbox_xmin),  32'(e.xmin));
                    chk("res_xmax",  32'(bbox_xmax),  32'(e.xmax));
                    chk("res_ymin",  32'(bbox_ymin),  32'(e.ymin));
                    chk("res_ymax",  32'(bbox_ymax),  32'(e.ymax));
                    chk("res_cnt",   32'(edge_cnt),   32'(e.cnt));
                    last_res = e;
                    ovl_on_m = ~e.empty;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        per_if.vsync = 1'b0; per_if.href = 1'b0; per_if.clken = 1'b0; per_if.data = 1'b0;
        clear_map();
        repeat (3) @(negedge clk);
        check_hold("rst");
        chk("rst_valid", 32'(bbox_valid), 32'd0);
        chk("rst_post_vsync", 32'(post_if.vsync), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);

        // Single edge
        clear_map(); pix_map[2][3] = 1'b1;
        run_frame("single", HD);
        // All zero
        clear_map();
        run_frame("zero", HD);
        // All one
        for (int y = 0; y < VD; y++) for (int x = 0; x < MAXW; x++) pix_map[y][x] = 1'b1;
        run_frame("ones", HD);
        // Two edges, 10-pixel lines with edges at x=8,9 ignored
        clear_map(); pix_map[4][1] = 1'b1; pix_map[1][6] = 1'b1;
        for (int y = 0; y < VD; y++) begin pix_map[y][8] = 1'b1; pix_map[y][9] = 1'b1; end
        run_frame("long", MAXW);

        // Reset mid-frame: nothing reported for the interrupted frame
        clear_map(); pix_map[0][2] = 1'b1; pix_map[1][5] = 1'b1; pix_map[3][4] = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        drive_line(0, HD);
        drive_line(1, HD);
        @(negedge clk);
        rst_n = 1'b0;
        last_res = '0;
        ovl_on_m = 1'b0;
        #1;
        check_hold("mid_rst");
        chk("mid_rst_post_vsync", 32'(post_if.vsync), 32'd0);
        chk("mid_rst_post_href",  32'(post_if.href),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_line(2, HD);
        drive_line(3, HD);
        tick(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        check_hold("after_rst");

        // Corner edges after reset
        clear_map(); pix_map[0][0] = 1'b1; pix_map[5][7] = 1'b1;
        run_frame("corner", HD);

        // Box (2,1)-(5,4), then an empty frame carrying the outline
        clear_map(); pix_map[1][2] = 1'b1; pix_map[4][5] = 1'b1;
        run_frame("box", HD);
        clear_map();
        count_ovl = 1'b1;
        ovl_cnt = 0;
        run_frame("ovl", HD);
        count_ovl = 1'b0;
`ifdef EDGE_BBOX_OVERLAY_EN
        chk("ovl_outline_pixels", 32'(ovl_cnt), 32'd12);
`else
        chk("ovl_outline_pixels", 32'(ovl_cnt), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("pending_results", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
